// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC and the fetched-entry type for the fetch unit
// Ports: none (package).
package fetch_pkg;

  localparam int ADDRWIDTH   = 32;
  localparam int DATAWIDTH   = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [ADDRWIDTH-1:0] START_ADDR = 32'h0100_0000;

  typedef struct packed {
    logic [ADDRWIDTH-1:0] pc;
    logic [DATAWIDTH-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; any low address bit set is a bad target.
  function automatic logic misaligned(input logic [ADDRWIDTH-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction-memory, redirect and decode-side signals of the fetch unit
// Ports: none; master = fetch unit side (drives imem address/controls, decode output, fault),
//        slave = environment side (memory read data, redirect, decode ready).
interface fetch_if;
  import fetch_pkg::*;

  logic [ADDRWIDTH-1:0] imem_address;
  logic                 imem_read_write;
  logic [DATAWIDTH-1:0] imem_data_in;
  logic [DATAWIDTH-1:0] imem_data_out;
  logic                 redirect_valid;
  logic [ADDRWIDTH-1:0] redirect_target;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDRWIDTH-1:0] out_pc;
  logic [DATAWIDTH-1:0] out_instr;
  logic                 fault;

  modport master (
    output imem_address, imem_read_write, imem_data_in,
    input  imem_data_out,
    input  redirect_valid, redirect_target,
    output out_valid, out_pc, out_instr, fault,
    input  out_ready
  );

  modport slave (
    input  imem_address, imem_read_write, imem_data_in,
    output imem_data_out,
    output redirect_valid, redirect_target,
    input  out_valid, out_pc, out_instr, fault,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous FIFO with push/pop/flush, count and full/empty flags
// Ports: clk, reset (sync, active high); push_i/data_i write side; pop_i read side;
//        flush_i empties the FIFO (wins over push/pop); head_o raw head entry;
//        count_o occupancy; full_o/empty_o status.
module fetch_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Storage is not reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction-memory initiator feeding decode through a small FIFO
// Ports: clk; reset (sync, active high); bus (fetch_if.master): imem_address/imem_read_write/
//        imem_data_in to memory, imem_data_out from memory, redirect_valid/redirect_target in,
//        out_valid/out_ready/out_pc/out_instr to decode, sticky fault out.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [ADDRWIDTH-1:0] pc_q, pc_d;
  logic                 fault_q, fault_d;

  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  fetch_entry_t         wr_entry, head_entry;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a fetch
  // when decode is draining it.
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = !fault_q && !bus.redirect_valid && (!fifo_full || pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = bus.imem_data_out;

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Redirect beats sequential fetch; once faulted nothing is pushed, so pc only
  // moves on further redirects.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_target;
      if (misaligned(bus.redirect_target)) fault_d = 1'b1;
    end else if (push) begin
      pc_d = pc_q + ADDRWIDTH'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= START_ADDR;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign bus.imem_address    = pc_q;
  assign bus.imem_read_write = 1'b0;
  assign bus.imem_data_in    = '0;

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_pc    = fifo_empty ? '0 : head_entry.pc;
  assign bus.out_instr = fifo_empty ? '0 : head_entry.instr;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h0100_0000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_if bus ();

  fetch_unit #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory word depends on the address but differs from it, so pc/instr swaps show.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_data_out = mw(bus.imem_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    step();
    step();

    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_addr", bus.imem_address, START);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_rw", 32'(bus.imem_read_write), 32'd0);
    chk("rst_din", bus.imem_data_in, 32'd0);

    // Streaming with decode always ready
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("str_valid", 32'(bus.out_valid), 32'd1);
      chk("str_pc", bus.out_pc, START + 32'(4*(k-1)));
      chk("str_instr", bus.out_instr, mw(START + 32'(4*(k-1))));
      chk("str_addr", bus.imem_address, START + 32'(4*k));
    end

    // Reset mid-stream, then backpressure
    reset = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("rst2_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_pc", bus.out_pc, START);
      chk("bp_addr", bus.imem_address, (k == 1) ? START + 32'd4 : START + 32'd8);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rel_valid", 32'(bus.out_valid), 32'd1);
      chk("rel_pc", bus.out_pc, START + 32'(4*k));
    end

    // Aligned redirect with a full FIFO and decode ready
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0100_0100;
    step();
    bus.redirect_valid = 1'b0;
    chk("rd_valid", 32'(bus.out_valid), 32'd0);
    chk("rd_pc", bus.out_pc, 32'd0);
    chk("rd_addr", bus.imem_address, 32'h0100_0100);
    step();
    chk("rd1_valid", 32'(bus.out_valid), 32'd1);
    chk("rd1_pc", bus.out_pc, 32'h0100_0100);
    chk("rd1_instr", bus.out_instr, 32'h5B5A_0100);
    step();
    chk("rd2_pc", bus.out_pc, 32'h0100_0104);

    // Misaligned redirect: sticky fault, fetch stops
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0100_0102;
    step();
    bus.redirect_valid = 1'b0;
    chk("mis_fault", 32'(bus.fault), 32'd1);
    chk("mis_valid", 32'(bus.out_valid), 32'd0);
    chk("mis_addr", bus.imem_address, 32'h0100_0102);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("mis_hold_valid", 32'(bus.out_valid), 32'd0);
      chk("mis_hold_fault", 32'(bus.fault), 32'd1);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0100_0200;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("mis_al_fault", 32'(bus.fault), 32'd1);
    chk("mis_al_valid", 32'(bus.out_valid), 32'd0);
    chk("mis_al_addr", bus.imem_address, 32'h0100_0200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mis_rst_fault", 32'(bus.fault), 32'd0);
    chk("mis_rst_addr", bus.imem_address, START);
    chk("mis_rst_valid", 32'(bus.out_valid), 32'd0);

    // PC wrap at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap_valid0", 32'(bus.out_valid), 32'd0);
    chk("wrap_addr0", bus.imem_address, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", bus.out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr1", bus.out_instr, 32'hA5A5_FFFC);
    chk("wrap_addr1", bus.imem_address, 32'h0000_0000);
    step();
    chk("wrap_pc2", bus.out_pc, 32'h0000_0000);
    chk("wrap_instr2", bus.out_instr, 32'h5A5A_0000);
    chk("wrap_addr2", bus.imem_address, 32'h0000_0004);

    // Reset with two entries buffered
    bus.out_ready = 1'b0;
    step();
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_pc", bus.out_pc, 32'h0000_0000);
    chk("full_addr", bus.imem_address, 32'h0000_0008);
    reset = 1'b1;
    step();
    chk("frst_valid", 32'(bus.out_valid), 32'd0);
    chk("frst_pc", bus.out_pc, 32'd0);
    chk("frst_addr", bus.imem_address, START);
    chk("frst_fault", 32'(bus.fault), 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("post_valid", 32'(bus.out_valid), 32'd1);
    chk("post_pc", bus.out_pc, START);
    chk("post_instr", bus.out_instr, 32'h5B5A_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
